// File: rtl/addsub_serial.sv
// Chunk-serial two's-complement adder/subtractor with signed overflow and carry-out.
// Optional saturation of Z on overflow when ADDSUB_SERIAL_SAT_EN is defined.
module addsub_serial #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] Z,
    output logic             overflow,
    output logic             carry_out
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic              carry_q, carry_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              a_msb_q, a_msb_d;
    logic              b_msb_q, b_msb_d;
    logic [WIDTH-1:0]  z_q, z_d;
    logic              ovf_q, ovf_d;
    logic              cout_q, cout_d;

    logic [CHUNK:0]    sum_s;
    logic [WIDTH-1:0]  raw_s;
    logic              last_s;
    logic              ovf_s;

`ifdef ADDSUB_SERIAL_SAT_EN
    function automatic logic [WIDTH-1:0] sat_value(input logic neg);
        return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
                else       state_d = S_IDLE;
            end
            S_RUN: begin
                if (last_s) state_d = S_DONE;
                else        state_d = S_RUN;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        ready = 1'b0;
        done  = 1'b0;
        case (state_q)
            S_IDLE:  ready = 1'b1;
            S_DONE:  done  = 1'b1;
            default: begin
                ready = 1'b0;
                done  = 1'b0;
            end
        endcase
    end

    // Chunk adder: operands shift right, results shift into the top of acc
    always_comb begin
        sum_s  = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
        raw_s  = (acc_q >> CHUNK) | (WIDTH'(sum_s[CHUNK-1:0]) << (WIDTH - CHUNK));
        last_s = (idx_q == IDXW'(NCHUNK - 1));
        ovf_s  = (a_msb_q == b_msb_q) && (raw_s[WIDTH-1] != a_msb_q);
    end

    // Datapath next-state
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        z_d     = z_q;
        ovf_d   = ovf_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = X;
                    b_d     = sub ? ~Y : Y;
                    a_msb_d = X[WIDTH-1];
                    b_msb_d = sub ? ~Y[WIDTH-1] : Y[WIDTH-1];
                    carry_d = sub;
                    acc_d   = {WIDTH{1'b0}};
                    idx_d   = {IDXW{1'b0}};
                end else begin
                    idx_d = idx_q;
                end
            end
            S_RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                acc_d   = raw_s;
                carry_d = sum_s[CHUNK];
                if (last_s) begin
                    idx_d  = {IDXW{1'b0}};
                    ovf_d  = ovf_s;
                    cout_d = sum_s[CHUNK];
`ifdef ADDSUB_SERIAL_SAT_EN
                    z_d    = ovf_s ? sat_value(a_msb_q) : raw_s;
`else
                    z_d    = raw_s;
`endif
                end else begin
                    idx_d = idx_q + {{(IDXW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                idx_d = idx_q;
            end
        endcase
    end

    // Datapath registers; results are only visible once complete
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            acc_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            idx_q   <= {IDXW{1'b0}};
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            z_q     <= {WIDTH{1'b0}};
            ovf_q   <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            z_q     <= z_d;
            ovf_q   <= ovf_d;
            cout_q  <= cout_d;
        end
    end

    assign Z         = z_q;
    assign overflow  = ovf_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench for addsub_serial: random and corner operations on a 32/8 instance,
// a 16/16 instance for the single-chunk case. Honors ADDSUB_SERIAL_SAT_EN.
module tb_addsub_serial;

    typedef struct {
        logic [31:0] z;
        logic        ovf;
        logic        cout;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, sub;
    logic [31:0] X, Y;
    logic        ready, done, overflow, carry_out;
    logic [31:0] Z;

    logic        start16, sub16;
    logic [15:0] x16, y16, z16;
    logic        ready16, done16, ovf16, cout16;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    addsub_serial #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .X(X), .Y(Y),
        .ready(ready), .done(done), .Z(Z), .overflow(overflow), .carry_out(carry_out)
    );

    addsub_serial #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .X(x16), .Y(y16),
        .ready(ready16), .done(done16), .Z(z16), .overflow(ovf16), .carry_out(cout16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: signed/unsigned integer arithmetic on 64-bit values
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
        exp_t   e;
        longint sx, sy, res;
        longint ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        res = s ? (sx - sy) : (sx + sy);
        e.ovf  = (res > 64'sd2147483647) || (res < -64'sd2147483648);
        e.cout = s ? (ux >= uy) : ((ux + uy) >= 64'sh100000000);
        e.z    = res[31:0];
`ifdef ADDSUB_SERIAL_SAT_EN
        if (e.ovf) e.z = (res > 64'sd0) ? 32'h7FFFFFFF : 32'h80000000;
`endif
        e.acc = 0;
        return e;
    endfunction

    task automatic push_exp();
        exp_t e;
        e = model(X, Y, sub);
        e.acc = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic wait_ready();
        int k;
        for (k = 0; k < 50; k++) begin
            if (ready) break;
            @(negedge clk);
        end
        if (!ready) chk("ready_timeout", ready, 1'b1);
    endtask

    task automatic op(input logic [31:0] x, input logic [31:0] y, input logic s);
        wait_ready();
        X = x; Y = y; sub = s; start = 1'b1;
        push_exp();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic op16(input logic [15:0] x, input logic [15:0] y, input logic s,
                        input logic [15:0] ez, input logic eo, input logic ec);
        chk("d16_ready_idle", ready16, 1'b1);
        x16 = x; y16 = y; sub16 = s; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        chk("d16_ready_run", ready16, 1'b0);
        chk("d16_done_early", done16, 1'b0);
        @(negedge clk);
        chk("d16_done", done16, 1'b1);
        chk("d16_z", z16, ez);
        chk("d16_ovf", ovf16, eo);
        chk("d16_cout", cout16, ec);
        @(negedge clk);
        chk("d16_done_pulse", done16, 1'b0);
        chk("d16_ready_back", ready16, 1'b1);
    endtask

    // Monitor: compare every done against the oldest expectation
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            chk("ready", ready, (sb.size() == 0));
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", done, 1'b0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("z", Z, mon_e.z);
                    chk("overflow", overflow, mon_e.ovf);
                    chk("carry_out", carry_out, mon_e.cout);
                    chk("latency", cyc, mon_e.acc + 4);
                end
            end
        end
    end

    initial begin
        int pushes;
        rst = 1'b1; start = 1'b0; sub = 1'b0; X = 32'd0; Y = 32'd0;
        start16 = 1'b0; sub16 = 1'b0; x16 = 16'd0; y16 = 16'd0;
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_z", Z, 32'd0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_cout", carry_out, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        op(32'h80000001, 32'h00000001, 1'b1);
        op(32'h80000000, 32'h00000001, 1'b1);
        op(32'h7FFFFFFF, 32'h00000001, 1'b0);
        op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        op(32'h00000000, 32'h00000001, 1'b1);
        op(32'h000000FF, 32'h00000001, 1'b0);
        op(32'h80000000, 32'h80000000, 1'b0);
        op(32'h12345678, 32'h12345678, 1'b1);

        for (int i = 0; i < 40; i++) begin
            op($urandom, $urandom, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // start held high; X changes while an operation is in flight
        wait_ready();
        X = 32'd5; Y = 32'd3; sub = 1'b0; start = 1'b1;
        pushes = 0;
        for (int i = 0; i < 36; i++) begin
            if (ready) begin
                push_exp();
                pushes++;
            end else if (pushes >= 3 && X == 32'd5) begin
                X = 32'd9;
            end
            @(negedge clk);
        end
        start = 1'b0;

        // reset in the middle of RUN discards the operation
        op(32'h0F0F0F0F, 32'h01010101, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", ready, 1'b1);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_z", Z, 32'd0);
        chk("mid_rst_ovf", overflow, 1'b0);
        chk("mid_rst_cout", carry_out, 1'b0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        op16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1);
`ifdef ADDSUB_SERIAL_SAT_EN
        op16(16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b0);
`else
        op16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1, 1'b0);
`endif
        op16(16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0);

        for (int k = 0; k < 100; k++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) chk("drain", sb.size(), 0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
